// File: rtl/rgb_pwm_fader.sv
// rtl/rgb_pwm_fader.sv - multi-channel PWM generator with period-synchronous duty fading
//
// Purpose:
//   A shared timebase produces ticks. A DEPTH-bit PWM counter runs 0 .. 2^DEPTH-2,
//   so one period is 2^DEPTH-1 ticks. Each channel output is high while the count
//   is below that channel's active duty. Active duties change only at period
//   boundaries, which keeps every period glitch free.
//
// Build option:
//   RGB_PWM_FADE_EN defined   - each boundary moves the duty toward its target by
//                               fade_step_i, saturating at the target.
//   RGB_PWM_FADE_EN undefined - each boundary copies the target into the duty;
//                               fade_step_i is ignored.
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_ni       synchronous active-low reset
//   enable_i     runs timebase and PWM; low clears counters and outputs
//   clk_div_i    tick period minus one, in clk_i cycles
//   target_i     packed target duties, channel c at [DEPTH*(c+1)-1 : DEPTH*c]
//   load_i       single-cycle strobe capturing target_i
//   fade_step_i  per-period duty step (0 freezes fading)
//   pwm_o        registered PWM outputs, active high
//   period_o     one-cycle pulse when the PWM counter returns to 0
//   done_o       high when every duty equals its target
module rgb_pwm_fader #(
  parameter int N_CH   = 6,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 16,
  parameter int STEP_W = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic [DIV_W-1:0]        clk_div_i,
  input  logic [N_CH*DEPTH-1:0]   target_i,
  input  logic                    load_i,
  input  logic [STEP_W-1:0]       fade_step_i,
  output logic [N_CH-1:0]         pwm_o,
  output logic                    period_o,
  output logic                    done_o
);

  // Last count of a period: 2^DEPTH-2.
  localparam logic [DEPTH-1:0] CNT_LAST = {{(DEPTH-1){1'b1}}, 1'b0};

  logic [DIV_W-1:0] div_cnt;
  logic [DEPTH-1:0] pwm_cnt;
  logic [DEPTH-1:0] pwm_cnt_nxt;
  logic             tick;
  logic             boundary;
  logic [DEPTH-1:0] duty_q   [N_CH];
  logic [DEPTH-1:0] tgt_q    [N_CH];
  logic [DEPTH-1:0] duty_nxt [N_CH];

  assign tick        = enable_i && (div_cnt == '0);
  assign boundary    = tick && (pwm_cnt == CNT_LAST);
  assign pwm_cnt_nxt = boundary ? '0 : pwm_cnt + DEPTH'(1);

`ifdef RGB_PWM_FADE_EN
  // Wide enough that duty +/- step can never wrap, whatever STEP_W is.
  localparam int AW = ((STEP_W > DEPTH) ? STEP_W : DEPTH) + 1;

  always_comb begin : fade_calc
    logic [AW-1:0] d;
    logic [AW-1:0] t;
    logic [AW-1:0] s;
    d = '0;
    t = '0;
    s = AW'(fade_step_i);
    for (int c = 0; c < N_CH; c++) begin
      duty_nxt[c] = duty_q[c];
      d = AW'(duty_q[c]);
      t = AW'(tgt_q[c]);
      if (boundary) begin
        // Land exactly on the target when the remaining gap is within one step.
        if (d < t) begin
          duty_nxt[c] = (t - d <= s) ? tgt_q[c] : DEPTH'(d + s);
        end else if (d > t) begin
          duty_nxt[c] = (d - t <= s) ? tgt_q[c] : DEPTH'(d - s);
        end
      end
    end
  end
`else
  logic unused_fade_step;
  assign unused_fade_step = ^fade_step_i;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      duty_nxt[c] = boundary ? tgt_q[c] : duty_q[c];
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_cnt  <= '0;
      pwm_cnt  <= '0;
      pwm_o    <= '0;
      period_o <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        duty_q[c] <= '0;
        tgt_q[c]  <= '0;
      end
    end else begin
      // Targets written here are first seen by the fade logic at the next
      // boundary, so a load landing on a boundary uses the old targets there.
      if (load_i) begin
        for (int c = 0; c < N_CH; c++) begin
          tgt_q[c] <= target_i[DEPTH*c +: DEPTH];
        end
      end
      for (int c = 0; c < N_CH; c++) begin
        duty_q[c] <= duty_nxt[c];
      end
      if (!enable_i) begin
        // Cleared counters make a re-enable start a fresh period at count 0.
        div_cnt  <= '0;
        pwm_cnt  <= '0;
        pwm_o    <= '0;
        period_o <= 1'b0;
      end else begin
        period_o <= boundary;
        if (tick) begin
          div_cnt <= clk_div_i;
          pwm_cnt <= pwm_cnt_nxt;
          // Compare against the post-boundary duty so a new period starts
          // with its new duty from count 0.
          for (int c = 0; c < N_CH; c++) begin
            pwm_o[c] <= (pwm_cnt_nxt < duty_nxt[c]);
          end
        end else begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
      end
    end
  end

  always_comb begin
    done_o = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (duty_q[c] != tgt_q[c]) done_o = 1'b0;
    end
  end

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 Parameter N_CH, default 6, number of PWM channels (for example 2 LEDs x 3 colours); range 1..32.
REQ-002 Parameter DEPTH, default 8, duty resolution in bits; range 2..12.
REQ-003 Parameter DIV_W, default 16, width of the timebase divider.
REQ-004 Parameter STEP_W, default 4, width of the fade step.
REQ-005 Port clk_i, input, 1, sole clock; all logic is on the rising edge.
REQ-006 Port rst_ni, input, 1, synchronous active-low reset.
REQ-007 Port enable_i, input, 1, runs the timebase and PWM when high.
REQ-008 Port clk_div_i, input, DIV_W, tick period minus 1, in clk_i cycles.
REQ-009 Port target_i, input, N_CH*DEPTH, target duties; channel c occupies bits [DEPTH*(c+1)-1 : DEPTH*c].
REQ-010 Port load_i, input, 1, single-cycle strobe that captures target_i into the target registers.
REQ-011 Port fade_step_i, input, STEP_W, per-period duty increment/decrement; 0 freezes fading.
REQ-012 Port pwm_o, output, N_CH, registered PWM outputs, active high.
REQ-013 Port period_o, output, 1, one-cycle pulse at each PWM period boundary.
REQ-014 Port done_o, output, 1, high when every channel's current duty equals its target.

Function
REQ-015 Timebase: down-counter; tick = (counter == 0); on tick it reloads clk_div_i, otherwise it decrements. clk_div_i = 0 gives a tick every cycle.
REQ-016 PWM counter (DEPTH bits) advances by 1 on each tick, counting 0 .. 2^DEPTH-2, then wraps to 0. A period is therefore 2^DEPTH-1 ticks.
REQ-017 Period boundary = a tick while the PWM counter equals 2^DEPTH-2. period_o pulses in the cycle after the boundary, aligned with the counter reaching 0.
REQ-018 On each tick, pwm_o[c] is registered as (next PWM count < active duty[c]), so pwm_o has 1-cycle latency from the tick.
REQ-019 Duty 0 gives pwm_o constantly low; duty 2^DEPTH-1 gives pwm_o constantly high.
REQ-020 Active duties update only at a period boundary, so no runt or glitch pulses occur within a period.
REQ-021 load_i captures target_i on the cycle it is high, regardless of enable_i.
REQ-022 If load_i coincides with a period boundary, the fade update at that boundary uses the previous targets; the new targets apply from the next boundary.
REQ-023 Fade update at each boundary, per channel:
  - if duty < target: duty = min(duty + fade_step_i, target);
  - if duty > target: duty = max(duty - fade_step_i, target);
  - arithmetic is carried out at DEPTH+1 bits, with no wrap-around past 0 or 2^DEPTH-1.
REQ-024 done_o is combinational AND over channels of (duty == target). It deasserts in the cycle after a load that changes any target.
REQ-025 enable_i low:
  - timebase, PWM counter, pwm_o and period_o are forced to 0 on the next edge;
  - duties and targets are retained.
  - Re-enabling starts a fresh period from count 0.

Reset
REQ-026 When rst_ni is low at a clock edge, the following clear to 0: timebase, PWM counter, all duties, all targets, pwm_o and period_o.
REQ-027 After reset, done_o = 1 and all outputs are low. Reset takes priority over load_i and enable_i.
REQ-028 Reset asserted mid-fade abandons the fade; no partial state survives.

Configuration
REQ-029 Macro RGB_PWM_FADE_EN:
  - defined: fade engine per REQ-023;
  - undefined: each duty copies its target directly at the next period boundary, and fade_step_i is ignored.
  - All other behaviour is identical in both builds.

Verification
REQ-030 N_CH=3, DEPTH=4, clk_div_i=0, target {15,0,5}, FADE undefined:
  - after the first boundary, ch0 is high for 15 of 15 ticks, ch1 for 0, ch2 for 5;
  - period_o fires every 15 cycles.
REQ-031 FADE defined, DEPTH=8, fade_step_i=4, target 0 -> 10:
  - duties are 4, 8, 10 at three consecutive boundaries;
  - done_o rises after the third boundary.
REQ-032 FADE defined, duty 250, target 255, step 15: duty saturates at 255 in one boundary with no wrap; the reverse case 3 -> 0 with step 15 gives 0.
REQ-033 load_i pulsed in the same cycle as a boundary: that boundary's update uses the old target, and the new target takes effect one period later.
REQ-034 clk_div_i=3: a tick occurs every 4 cycles. Drop enable_i mid-period: pwm_o is 0 on the next edge. Re-enable: the period restarts at count 0 with duties unchanged.
REQ-035 Drop rst_ni mid-fade for 1 cycle: all outputs 0, done_o=1, and the fade restarts only after a new load_i.
